// File: rtl/collision_score.sv
// Per-frame collision detector and BCD score / lives keeper for a pixel-driven shooter.
// Optional COLLISION_SCORE_LIVES_EN enables ship hits, lives and the GAME_OVER state.
module collision_score #(
  parameter int START_LIVES = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        v_sync,
  input  logic        bullet_on,
  input  logic        enemy_on,
  input  logic        ship_on,
  input  logic        restart,
  output logic        enemy_hit,
  output logic        ship_hit,
  output logic [15:0] score,
  output logic [1:0]  lives,
  output logic        game_over
);

  typedef enum logic {
    S_PLAY      = 1'b0,
    S_GAME_OVER = 1'b1
  } state_t;

  localparam logic [1:0]  LP_START_LIVES = 2'(START_LIVES);
  localparam logic [15:0] LP_SCORE_MAX   = 16'h9999;

  state_t      r_state;
  state_t      w_state_next;
  logic        r_vsync_d;
  logic        r_bullet_flag;
  logic        r_enemy_hit;
  logic        r_ship_hit;
  logic [15:0] r_score;
  logic [1:0]  r_lives;

  logic        w_frame_tick;
  logic        w_play;
  logic        w_bullet_ov;
  logic        w_score_ev;
  logic        w_ship_ev;
  logic        w_restart;

  // Saturating four-digit BCD increment; a carry ripples only through digits at 9.
  function automatic logic [15:0] bcd_inc(input logic [15:0] value);
    logic [15:0] result;
    logic        carry;
    result = value;
    carry  = 1'b1;
    if (value != LP_SCORE_MAX) begin
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (result[4*i +: 4] == 4'd9) begin
            result[4*i +: 4] = 4'd0;
          end else begin
            result[4*i +: 4] = result[4*i +: 4] + 4'd1;
            carry            = 1'b0;
          end
        end
      end
    end
    return result;
  endfunction

  assign w_frame_tick = v_sync & ~r_vsync_d;
  assign w_play       = (r_state == S_PLAY);
  assign w_bullet_ov  = bullet_on & enemy_on;
  // Overlap in the closing cycle itself still belongs to the frame being closed.
  assign w_score_ev   = w_frame_tick & w_play & (r_bullet_flag | w_bullet_ov);

`ifdef COLLISION_SCORE_LIVES_EN
  logic r_ship_flag;
  logic w_ship_ov;

  assign w_ship_ov = ship_on & enemy_on;
  assign w_ship_ev = w_frame_tick & w_play & (r_ship_flag | w_ship_ov);
  assign w_restart = w_frame_tick & ~w_play & restart;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ship_flag <= 1'b0;
    end else if (w_frame_tick) begin
      r_ship_flag <= 1'b0;
    end else if (w_play) begin
      r_ship_flag <= r_ship_flag | w_ship_ov;
    end
  end
`else
  logic w_unused_cfg;

  assign w_ship_ev    = 1'b0;
  assign w_restart    = 1'b0;
  assign w_unused_cfg = ship_on ^ restart;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_PLAY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_PLAY: begin
        if (w_ship_ev && (r_lives == 2'd1)) begin
          w_state_next = S_GAME_OVER;
        end
      end
      S_GAME_OVER: begin
        if (w_restart) begin
          w_state_next = S_PLAY;
        end
      end
      default: w_state_next = S_PLAY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample
  // the same pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vsync_d     <= 1'b0;
      r_bullet_flag <= 1'b0;
      r_enemy_hit   <= 1'b0;
      r_ship_hit    <= 1'b0;
      r_score       <= 16'h0000;
      r_lives       <= LP_START_LIVES;
    end else begin
      r_vsync_d   <= v_sync;
      r_enemy_hit <= w_score_ev;
      r_ship_hit  <= w_ship_ev;

      if (w_frame_tick) begin
        r_bullet_flag <= 1'b0;
      end else if (w_play) begin
        r_bullet_flag <= r_bullet_flag | w_bullet_ov;
      end

      if (w_score_ev) begin
        r_score <= bcd_inc(r_score);
      end
      if (w_ship_ev) begin
        r_lives <= r_lives - 2'd1;
      end
      if (w_restart) begin
        r_score <= 16'h0000;
        r_lives <= LP_START_LIVES;
      end
    end
  end

  assign enemy_hit = r_enemy_hit;
  assign ship_hit  = r_ship_hit;
  assign score     = r_score;
  assign lives     = r_lives;
  assign game_over = (r_state == S_GAME_OVER);

endmodule

// File: tb/tb_collision_score.sv
// Scoreboard bench for collision_score: a frame-level reference model queues the
// expected outcome of every closed frame; a monitor compares the DUT each cycle.
module tb_collision_score;

  localparam int START_LIVES = 3;
`ifdef COLLISION_SCORE_LIVES_EN
  localparam bit LIVES_EN = 1'b1;
`else
  localparam bit LIVES_EN = 1'b0;
`endif

  typedef struct packed {
    logic        eh;
    logic        sh;
    logic [15:0] sc;
    logic [1:0]  lv;
    logic        go;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        v_sync = 1'b0;
  logic        bullet_on = 1'b0;
  logic        enemy_on = 1'b0;
  logic        ship_on = 1'b0;
  logic        restart = 1'b0;
  logic        enemy_hit;
  logic        ship_hit;
  logic [15:0] score;
  logic [1:0]  lives;
  logic        game_over;

  int   n_checks = 0;
  int   n_fail   = 0;
  obs_t exp_q[$];

  // Reference model state: score as a plain integer, frame-scoped overlap memory.
  int m_score;
  int m_lives;
  bit m_over;
  bit m_bullet_seen;
  bit m_ship_seen;
  bit m_vs_prev;

  collision_score #(.START_LIVES(START_LIVES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .v_sync    (v_sync),
    .bullet_on (bullet_on),
    .enemy_on  (enemy_on),
    .ship_on   (ship_on),
    .restart   (restart),
    .enemy_hit (enemy_hit),
    .ship_hit  (ship_hit),
    .score     (score),
    .lives     (lives),
    .game_over (game_over)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int value);
    return {4'(value / 1000), 4'((value / 100) % 10), 4'((value / 10) % 10), 4'(value % 10)};
  endfunction

  function automatic obs_t reset_obs();
    obs_t o;
    o.eh = 1'b0;
    o.sh = 1'b0;
    o.sc = 16'h0000;
    o.lv = 2'(START_LIVES);
    o.go = 1'b0;
    return o;
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s t=%0t: got eh=%0b sh=%0b score=%h lives=%0d go=%0b, want eh=%0b sh=%0b score=%h lives=%0d go=%0b",
               name, $time, act.eh, act.sh, act.sc, act.lv, act.go,
               want.eh, want.sh, want.sc, want.lv, want.go);
    end
  endtask

  task automatic model_reset();
    m_score       = 0;
    m_lives       = START_LIVES;
    m_over        = 1'b0;
    m_bullet_seen = 1'b0;
    m_ship_seen   = 1'b0;
    m_vs_prev     = 1'b0;
  endtask

  // Apply one cycle of inputs; when it closes a frame, queue that frame's outcome.
  task automatic drive(input bit vs, input bit b, input bit e, input bit s, input bit r);
    bit   bov;
    bit   sov;
    bit   hit_b;
    bit   hit_s;
    obs_t x;
    v_sync    = vs;
    bullet_on = b;
    enemy_on  = e;
    ship_on   = s;
    restart   = r;
    bov = b && e;
    sov = s && e;
    if (vs && !m_vs_prev) begin
      hit_b = !m_over && (m_bullet_seen || bov);
      hit_s = LIVES_EN && !m_over && (m_ship_seen || sov);
      if (m_over) begin
        if (r) begin
          m_score = 0;
          m_lives = START_LIVES;
          m_over  = 1'b0;
        end
      end else begin
        if (hit_b && m_score < 9999) m_score++;
        if (hit_s) begin
          m_lives--;
          if (m_lives == 0) m_over = 1'b1;
        end
      end
      x.eh = hit_b;
      x.sh = hit_s;
      x.sc = to_bcd(m_score);
      x.lv = 2'(m_lives);
      x.go = m_over;
      exp_q.push_back(x);
      m_bullet_seen = 1'b0;
      m_ship_seen   = 1'b0;
    end else if (!m_over) begin
      m_bullet_seen = m_bullet_seen || bov;
      m_ship_seen   = m_ship_seen || sov;
    end
    m_vs_prev = vs;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    rst_n     = 1'b0;
    v_sync    = 1'b0;
    bullet_on = 1'b0;
    enemy_on  = 1'b0;
    ship_on   = 1'b0;
    restart   = 1'b0;
    model_reset();
    repeat (cycles) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: outputs after a frame close must match the queued outcome; every
  // other cycle must show no pulses and unchanged score/lives/game_over.
  obs_t mon_cur;
  bit   mon_pending = 1'b0;
  bit   mon_vs_prev = 1'b0;

  always @(negedge clk) begin
    obs_t act;
    obs_t want;
    act.eh = enemy_hit;
    act.sh = ship_hit;
    act.sc = score;
    act.lv = lives;
    act.go = game_over;
    if (!rst_n) begin
      check("reset_state", act, reset_obs());
      exp_q.delete();
      mon_cur     = reset_obs();
      mon_pending = 1'b0;
      mon_vs_prev = 1'b0;
    end else begin
      if (mon_pending) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL scoreboard_empty t=%0t: frame closed with no expected entry", $time);
        end else begin
          want = exp_q.pop_front();
          check("frame_result", act, want);
          mon_cur    = want;
          mon_cur.eh = 1'b0;
          mon_cur.sh = 1'b0;
        end
      end else begin
        check("between_frames", act, mon_cur);
      end
      mon_pending = v_sync && !mon_vs_prev;
      mon_vs_prev = v_sync;
    end
  end

  initial begin
    model_reset();
    do_reset(3);
    drive(0, 0, 0, 0, 0);

    // Five overlap cycles in one frame give a single hit.
    repeat (5) drive(0, 1, 1, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);

    // Overlap only in the closing cycle, and restart while playing.
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1);
    drive(1, 1, 1, 0, 1);
    drive(0, 0, 0, 0, 0);

    // Three ship frames, bullet too on the last, then GAME_OVER and restart.
    do_reset(2);
    for (int f = 0; f < 3; f++) begin
      drive(0, 0, 1, 1, 0);
      drive(0, (f == 2), 1, 0, 0);
      drive(1, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0);
    end
    drive(0, 1, 1, 1, 0);
    drive(1, 1, 1, 1, 0);
    drive(0, 1, 1, 1, 1);
    drive(1, 1, 1, 1, 1);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);

    // Reset mid-frame discards the pending overlap.
    repeat (3) drive(0, 1, 1, 1, 0);
    do_reset(2);
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);

    // Ship-only frames.
    do_reset(2);
    for (int f = 0; f < 4; f++) begin
      drive(0, 0, 1, 1, 0);
      drive(1, 0, 0, 0, 0);
    end
    drive(0, 0, 0, 0, 0);

    // Randomized traffic.
    do_reset(2);
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 3) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
            ($urandom_range(0, 3) == 0), $urandom_range(0, 1));
    end

    // Walk the score to 9999, then one more hit frame must saturate.
    do_reset(2);
    for (int f = 0; f < 10000; f++) begin
      drive(0, 1, 1, 0, 0);
      drive(1, 0, 0, 0, 0);
    end
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);

    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
